// File: rtl/sisc_mux_pipe.sv
// Registered N:1 operand mux with valid/ready handshake and a one-entry skid buffer.
// Out-of-range selects forward the last in-range word and are counted.
module sisc_mux_pipe #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_f,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    flush,
  output logic                    sel_err,
  output logic [7:0]              err_cnt
);

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic [WIDTH-1:0] skid_data_r;
  logic             skid_valid_r;
  logic [WIDTH-1:0] last_good_r;

  logic [WIDTH-1:0] pick_s;
  logic [WIDTH-1:0] word_s;
  logic             sel_ok_s;
  logic             accept_s;
  logic             bad_s;
  logic [WIDTH-1:0] out_data_s;
  logic             out_valid_s;
  logic [WIDTH-1:0] skid_data_s;
  logic             skid_valid_s;

  // Channel pick and select range check
  always_comb begin
    pick_s = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if ({1'b0, sel} == (SEL_W+1)'(k)) begin
        pick_s = in_data[k*WIDTH +: WIDTH];
      end else begin
        pick_s = pick_s;
      end
    end
    sel_ok_s = ({1'b0, sel} < NUM_IN_W);
    word_s   = sel_ok_s ? pick_s : last_good_r;
    accept_s = in_valid && in_ready;
    bad_s    = accept_s && !flush && !sel_ok_s;
  end

  // Next contents of output and skid registers; flush overrides everything
  always_comb begin
    out_data_s   = out_data;
    out_valid_s  = out_valid;
    skid_data_s  = skid_data_r;
    skid_valid_s = skid_valid_r;
    if (flush) begin
      out_valid_s  = 1'b0;
      skid_valid_s = 1'b0;
    end else begin
      case ({out_valid, skid_valid_r})
        2'b00: begin
          if (accept_s) begin
            out_valid_s = 1'b1;
            out_data_s  = word_s;
          end else begin
            out_valid_s = 1'b0;
          end
        end
        2'b10: begin
          if (accept_s && out_ready) begin
            out_data_s = word_s;
          end else if (accept_s) begin
            skid_valid_s = 1'b1;
            skid_data_s  = word_s;
          end else if (out_ready) begin
            out_valid_s = 1'b0;
          end else begin
            out_valid_s = 1'b1;
          end
        end
        2'b11: begin
          if (out_ready) begin
            out_data_s   = skid_data_r;
            skid_valid_s = 1'b0;
          end else begin
            skid_valid_s = 1'b1;
          end
        end
        default: begin
          out_valid_s  = 1'b0;
          skid_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State, status and error registers
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      out_data     <= '0;
      out_valid    <= 1'b0;
      skid_data_r  <= '0;
      skid_valid_r <= 1'b0;
      in_ready     <= 1'b1;
      last_good_r  <= '0;
      sel_err      <= 1'b0;
      err_cnt      <= 8'd0;
    end else begin
      out_data     <= out_data_s;
      out_valid    <= out_valid_s;
      skid_data_r  <= skid_data_s;
      skid_valid_r <= skid_valid_s;
      in_ready     <= !skid_valid_s;
      sel_err      <= bad_s;
      if (bad_s && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end else begin
        err_cnt <= err_cnt;
      end
      // A flushed beat never becomes the fallback word
      if (accept_s && !flush && sel_ok_s) begin
        last_good_r <= pick_s;
      end else begin
        last_good_r <= last_good_r;
      end
    end
  end

endmodule

// File: tb/tb_sisc_mux_pipe.sv
// Bench for sisc_mux_pipe: a NUM_IN=4 instance for the plain select sweep and a
// NUM_IN=3 instance checked against a two-slot queue model.
module tb_sisc_mux_pipe;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [63:0] in_data;
  logic [1:0]  sel;
  logic        in_valid, out_ready, flush;

  logic        in_ready4, out_valid4, sel_err4;
  logic [15:0] out_data4;
  logic [7:0]  err_cnt4;
  logic        in_ready, out_valid, sel_err;
  logic [15:0] out_data;
  logic [7:0]  err_cnt;

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] mq[$];
  logic [15:0] m_last;
  int          m_cnt;
  bit          m_err;

  always #5 clk = ~clk;

  sisc_mux_pipe #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .rst_f(rst_f), .in_data(in_data), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready), .flush(flush), .sel_err(sel_err4), .err_cnt(err_cnt4)
  );

  sisc_mux_pipe #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_f(rst_f), .in_data(in_data[47:0]), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .flush(flush), .sel_err(sel_err), .err_cnt(err_cnt)
  );

  task automatic model_clear();
    mq.delete();
    m_last = 16'h0000;
    m_cnt  = 0;
    m_err  = 1'b0;
  endtask

  // One clock: reference model of the NUM_IN=3 instance as a 2-deep FIFO
  task automatic tick();
    bit          acc;
    logic [15:0] w;
    acc = in_valid && (mq.size() < 2);
    w   = (sel < 2'd3) ? in_data[int'(sel)*16 +: 16] : m_last;
    @(posedge clk);
    #1;
    if (flush) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(w);
        if (sel < 2'd3) m_last = w;
      end
      m_err = acc && (sel == 2'd3);
      if (m_err && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst_f = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; sel = 2'd0;
    in_data = 64'h0;
    model_clear();
    #12;
    n_total++; if (out_valid !== 1'b0 || out_valid4 !== 1'b0) $display("FAIL reset_out_valid got %b/%b want 0", out_valid, out_valid4); else n_pass++;
    n_total++; if (out_data !== 16'h0000) $display("FAIL reset_out_data got %h want 0000", out_data); else n_pass++;
    n_total++; if (sel_err !== 1'b0 || err_cnt !== 8'd0) $display("FAIL reset_err got %b/%0d want 0/0", sel_err, err_cnt); else n_pass++;
    #1 rst_f = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1 || in_ready4 !== 1'b1) $display("FAIL reset_in_ready got %b/%b want 1", in_ready, in_ready4); else n_pass++;
  endtask

  task automatic test_basic_select();
    logic [15:0] exp4 [4];
    exp4 = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
    in_data = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    out_ready = 1'b1; in_valid = 1'b1; flush = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      tick();
      n_total++; if (out_valid4 !== 1'b1 || out_data4 !== exp4[s]) $display("FAIL basic_sel%0d got %b/%h want 1/%h", s, out_valid4, out_data4, exp4[s]); else n_pass++;
    end
    n_total++; if (out_data !== 16'h000C || sel_err !== 1'b1) $display("FAIL basic_n3_sel3 got %h/%b want 000c/1", out_data, sel_err); else n_pass++;
    drain();
  endtask

  task automatic test_back_pressure();
    in_data = {16'h0000, 16'h2222, 16'h1111, 16'h0000};
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
    tick();
    n_total++; if (out_data !== 16'h1111 || out_valid !== 1'b1 || in_ready !== 1'b1) $display("FAIL bp_first got %h/%b/%b want 1111/1/1", out_data, out_valid, in_ready); else n_pass++;
    sel = 2'd2;
    tick();
    n_total++; if (out_data !== 16'h1111 || in_ready !== 1'b0) $display("FAIL bp_full got %h/%b want 1111/0", out_data, in_ready); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_total++; if (out_data !== 16'h1111 || out_valid !== 1'b1) $display("FAIL bp_stable got %h/%b want 1111/1", out_data, out_valid); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_total++; if (out_data !== 16'h2222 || out_valid !== 1'b1 || in_ready !== 1'b1) $display("FAIL bp_second got %h/%b/%b want 2222/1/1", out_data, out_valid, in_ready); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    rst_f = 1'b0; in_valid = 1'b0; #2 rst_f = 1'b1;
    model_clear();
    in_data = {16'h0000, 16'h0000, 16'hBEEF, 16'h1234};
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd1;
    tick();
    n_total++; if (out_data !== 16'hBEEF || sel_err !== 1'b0) $display("FAIL oor_good got %h/%b want beef/0", out_data, sel_err); else n_pass++;
    sel = 2'd3; in_data = 64'h0;
    tick();
    n_total++; if (out_data !== 16'hBEEF || out_valid !== 1'b1) $display("FAIL oor_word got %h/%b want beef/1", out_data, out_valid); else n_pass++;
    n_total++; if (sel_err !== 1'b1 || err_cnt !== 8'd1) $display("FAIL oor_err got %b/%0d want 1/1", sel_err, err_cnt); else n_pass++;
    in_valid = 1'b0;
    tick();
    n_total++; if (sel_err !== 1'b0) $display("FAIL oor_pulse got %b want 0", sel_err); else n_pass++;
    in_valid = 1'b1; sel = 2'd3;
    for (int i = 0; i < 300; i++) tick();
    n_total++; if (err_cnt !== 8'd255) $display("FAIL oor_saturate got %0d want 255", err_cnt); else n_pass++;
    n_total++; if (out_data !== 16'hBEEF) $display("FAIL oor_last_good got %h want beef", out_data); else n_pass++;
    drain();
  endtask

  task automatic test_flush();
    logic [7:0] cnt0;
    @(negedge clk);
    rst_f = 1'b0; in_valid = 1'b0; #2 rst_f = 1'b1;
    model_clear();
    in_data = {16'h0000, 16'h0000, 16'h2B2B, 16'h1A1A};
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
    tick(); sel = 2'd1; tick();
    n_total++; if (in_ready !== 1'b0) $display("FAIL flush_fill got %b want 0", in_ready); else n_pass++;
    sel = 2'd3; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    cnt0 = err_cnt;
    in_valid = 1'b1; sel = 2'd0; out_ready = 1'b0;
    tick(); tick();
    flush = 1'b1; in_valid = 1'b1; sel = 2'd3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_full got %b/%b want 0/1", out_valid, in_ready); else n_pass++;
    out_ready = 1'b1;
    tick(); tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_no_out got %b want 0", out_valid); else n_pass++;
    flush = 1'b1; in_valid = 1'b1; sel = 2'd3;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b0 || sel_err !== 1'b0 || err_cnt !== cnt0) $display("FAIL flush_accept got %b/%b/%0d want 0/0/%0d", out_valid, sel_err, err_cnt, cnt0); else n_pass++;
    sel = 2'd1; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    n_total++; if (out_data !== 16'h2B2B || err_cnt !== cnt0) $display("FAIL flush_keep got %h/%0d want 2b2b/%0d", out_data, err_cnt, cnt0); else n_pass++;
    drain();
  endtask

  task automatic test_async_reset();
    in_data = {16'h0000, 16'h0000, 16'h0303, 16'h0202};
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
    tick(); sel = 2'd0; tick();
    in_valid = 1'b0;
    #3 rst_f = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || in_ready !== 1'b1) $display("FAIL areset_out got %b/%h/%b want 0/0000/1", out_valid, out_data, in_ready); else n_pass++;
    n_total++; if (sel_err !== 1'b0 || err_cnt !== 8'd0) $display("FAIL areset_err got %b/%0d want 0/0", sel_err, err_cnt); else n_pass++;
    #1 rst_f = 1'b1;
    model_clear();
    in_data = {16'h0000, 16'h0000, 16'h0000, 16'h5A5A};
    out_ready = 1'b1; in_valid = 1'b1; sel = 2'd0;
    tick();
    in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b1 || out_data !== 16'h5A5A) $display("FAIL areset_first got %b/%h want 1/5a5a", out_valid, out_data); else n_pass++;
    drain();
  endtask

  task automatic test_random_soak();
    int bad;
    bad = 0;
    for (int c = 0; c < 10000; c++) begin
      in_data   = {$urandom, $urandom};
      sel       = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      tick();
      n_total++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2) ||
          (mq.size() > 0 && out_data !== mq[0])) begin
        bad++;
        $display("FAIL soak_data cyc %0d got v=%b r=%b d=%h want v=%b r=%b d=%h", c, out_valid, in_ready, out_data,
                 mq.size() > 0, mq.size() < 2, (mq.size() > 0) ? mq[0] : 16'h0);
      end else n_pass++;
      n_total++;
      if (sel_err !== m_err || err_cnt !== 8'(m_cnt)) begin
        bad++;
        $display("FAIL soak_err cyc %0d got %b/%0d want %b/%0d", c, sel_err, err_cnt, m_err, m_cnt);
      end else n_pass++;
      if (bad > 20) break;
    end
    flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_select();
    test_back_pressure();
    test_out_of_range();
    test_flush();
    test_async_reset();
    test_random_soak();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
